sd_cmd_transmit: RTL and testbench

//   Host-side SD CMD-line transmitter: serializes a 48-bit command token
//   (start 0, transmission 1, 6-bit index, 32-bit argument, CRC7, end 1), MSB first.

---
 rtl/sd_defs_pkg.sv | 26 ++
 rtl/sd_crc7.sv | 32 +++
 rtl/sd_cmd_transmit.sv | 141 ++++++++++++++
 tb/tb_sd_cmd_transmit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sd_defs_pkg.sv
// Shared SD CMD-line definitions: token geometry, CRC7 polynomial, FSM encodings.
// Used by both the command transmitter and the response receiver.
package sd_defs;

    localparam int CMD_W     = 48;
    localparam int CRC_W     = 7;
    localparam int PAYLOAD_W = CMD_W - CRC_W - 1;

    localparam logic [6:0] CRC7_POLY = 7'h09;
    localparam logic       START_BIT = 1'b0;
    localparam logic       TRANS_BIT = 1'b1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SEND = 3'd1;
    localparam logic [2:0] ST_CRC  = 3'd2;
    localparam logic [2:0] ST_STOP = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    // One serial step of CRC7 (x^7 + x^3 + 1), MSB-first data.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator; clear has priority over en. Shared with the receive path.
import sd_defs::*;

module sd_crc7 (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear)
            crc_d = '0;
        else if (en)
            crc_d = crc7_step(crc_q, din);
    end

    always_ff @(posedge clk) begin
        if (!reset)
            crc_q <= '0;
        else
            crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_transmit.sv
// Host SD CMD-line transmitter: serializes start/trans/index/arg/CRC7/end, MSB first,
// then holds busy through an NCC gap with the pad released.
import sd_defs::*;

module sd_cmd_transmit #(
    parameter int GAP_CYCLES = 8
) (
    input  logic        sd_clk,
    input  logic        reset,
    input  logic        en,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    output logic        busy,
    output logic        done
);

    logic [2:0]           state_q, state_d;
    logic [PAYLOAD_W-1:0] shift_q, shift_d;
    logic [5:0]           cnt_q, cnt_d;
    logic                 out_q, out_d;
    logic                 oe_q, oe_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 accept;
    logic [6:0]           crc;

    assign accept = (state_q == ST_IDLE) && en;

    sd_crc7 u_crc7 (
        .clk   (sd_clk),
        .reset (reset),
        .clear (accept),
        .en    (state_q == ST_SEND),
        .din   (shift_q[PAYLOAD_W-1]),
        .crc   (crc)
    );

    // Pad outputs are registered: the line shows what the FSM emitted on the previous edge.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        out_d   = 1'b1;
        oe_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = en;
                if (en) begin
                    shift_d = {START_BIT, TRANS_BIT, cmd_index, cmd_arg};
                    cnt_d   = 6'(PAYLOAD_W);
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                out_d   = shift_q[PAYLOAD_W-1];
                oe_d    = 1'b1;
                shift_d = {shift_q[PAYLOAD_W-2:0], 1'b0};
                if (cnt_q == 6'd1) begin
                    cnt_d   = 6'(CRC_W);
                    state_d = ST_CRC;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end

            ST_CRC: begin
                // The CRC is final once SEND ends; walk it MSB first by counter.
                out_d = crc[3'(cnt_q - 6'd1)];
                oe_d  = 1'b1;
                if (cnt_q == 6'd1) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end

            ST_STOP: begin
                out_d = 1'b1;
                oe_d  = 1'b1;
                if (GAP_CYCLES == 0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = 6'(GAP_CYCLES);
                    state_d = ST_GAP;
                end
            end

            ST_GAP: begin
                // IDLE during the done cycle lets a held en restart with no extra bubble.
                if (cnt_q <= 6'd1) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end

            default: begin
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sd_clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b1;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sd_cmd_out = out_q;
    assign sd_cmd_oe  = oe_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sd_cmd_transmit.sv
// Directed bench for sd_cmd_transmit: known CMD tokens, en-while-busy, mid-frame reset,
// and back-to-back frames with a zero gap.
module tb_sd_cmd_transmit;

    logic        sd_clk = 1'b0;
    logic        reset;
    logic        en, en0;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        sd_cmd_out, sd_cmd_oe, busy, done;
    logic        out0, oe0, busy0, done0;

    int checks = 0;
    int errors = 0;

    always #5 sd_clk = ~sd_clk;

    sd_cmd_transmit #(.GAP_CYCLES(8)) u_dut (
        .sd_clk     (sd_clk),
        .reset      (reset),
        .en         (en),
        .cmd_index  (cmd_index),
        .cmd_arg    (cmd_arg),
        .sd_cmd_out (sd_cmd_out),
        .sd_cmd_oe  (sd_cmd_oe),
        .busy       (busy),
        .done       (done)
    );

    sd_cmd_transmit #(.GAP_CYCLES(0)) u_dut0 (
        .sd_clk     (sd_clk),
        .reset      (reset),
        .en         (en0),
        .cmd_index  (cmd_index),
        .cmd_arg    (cmd_arg),
        .sd_cmd_out (out0),
        .sd_cmd_oe  (oe0),
        .busy       (busy0),
        .done       (done0)
    );

    task automatic chk(input string tag, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge sd_clk);
        @(negedge sd_clk);
    endtask

    // Starts a frame on u_dut from a negedge and checks it end to end.
    // s counts cycles after the accepting edge: bits at s=1..48, gap s=49..56, done at s=56.
    task automatic run_frame(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                             input logic [47:0] exp_frame, input bit poke);
        logic [47:0] cap;
        int oe_bad, busy_bad, dones, done_at;
        cap = '0; oe_bad = 0; busy_bad = 0; dones = 0; done_at = -1;
        cmd_index = idx; cmd_arg = arg; en = 1'b1;
        tick();
        en = 1'b0;
        chk({tag, "_s0_oe"}, sd_cmd_oe, 1'b0);
        chk({tag, "_s0_busy"}, busy, 1'b1);
        cmd_index = 6'h3f; cmd_arg = 32'hffff_ffff;
        for (int s = 1; s <= 48; s++) begin
            if (poke && (s == 5 || s == 30)) begin
                en = 1'b1; cmd_index = 6'd2;
            end else begin
                en = 1'b0;
            end
            tick();
            cap = {cap[46:0], sd_cmd_out};
            if (!sd_cmd_oe) oe_bad++;
            if (!busy) busy_bad++;
            if (done) dones++;
        end
        en = 1'b0;
        for (int s = 49; s <= 60; s++) begin
            tick();
            if (sd_cmd_oe || !sd_cmd_out) oe_bad++;
            if (s <= 56 && !busy) busy_bad++;
            if (s >= 57 && busy) busy_bad++;
            if (done) begin dones++; done_at = s; end
        end
        chk({tag, "_frame"}, cap, exp_frame);
        chk({tag, "_oe_window"}, 48'(oe_bad), 48'd0);
        chk({tag, "_busy_window"}, 48'(busy_bad), 48'd0);
        chk({tag, "_done_count"}, 48'(dones), 48'd1);
        chk({tag, "_done_cycle"}, 48'(done_at), 48'd56);
    endtask

    initial begin
        logic [47:0] f1, f2;
        logic        oe_tr [0:99];
        logic        out_tr[0:99];
        logic        dn_tr [0:99];
        int bad, dones, busy_bad;

        reset = 1'b0; en = 1'b0; en0 = 1'b0; cmd_index = '0; cmd_arg = '0;
        repeat (3) tick();
        chk("rst_out", sd_cmd_out, 1'b1);
        chk("rst_oe", sd_cmd_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst0_line", {out0, oe0, busy0, done0}, 4'b1000);
        reset = 1'b1;
        repeat (2) tick();

        run_frame("cmd0",  6'd0,  32'h0000_0000, 48'h40_0000_0000_95, 1'b0);
        run_frame("cmd8",  6'd8,  32'h0000_01AA, 48'h48_0000_01AA_87, 1'b0);
        run_frame("cmd17", 6'd17, 32'h0000_0000, 48'h51_0000_0000_55, 1'b0);
        run_frame("cmd55", 6'd55, 32'h0000_0000, 48'h77_0000_0000_65, 1'b1);

        // Abort a frame with reset while bit 20 is on the line.
        cmd_index = 6'd8; cmd_arg = 32'h0000_01AA; en = 1'b1;
        tick();
        en = 1'b0;
        for (int s = 1; s <= 20; s++) tick();
        chk("abort_pre_oe", sd_cmd_oe, 1'b1);
        reset = 1'b0;
        tick();
        chk("abort_line", {sd_cmd_out, sd_cmd_oe, busy, done}, 4'b1000);
        reset = 1'b1;
        bad = 0;
        for (int s = 0; s < 60; s++) begin
            tick();
            if (done || busy || sd_cmd_oe) bad++;
        end
        chk("abort_quiet", 48'(bad), 48'd0);
        run_frame("post_abort", 6'd8, 32'h0000_01AA, 48'h48_0000_01AA_87, 1'b0);

        // Zero-gap instance with en held high: frames at s=1..48 and s=50..97.
        cmd_index = 6'd0; cmd_arg = 32'h0; en0 = 1'b1;
        for (int s = 0; s < 100; s++) begin
            tick();
            oe_tr[s] = oe0; out_tr[s] = out0; dn_tr[s] = done0;
        end
        en0 = 1'b0;
        f1 = '0; f2 = '0; bad = 0; dones = 0;
        for (int s = 1; s <= 48; s++) begin
            f1 = {f1[46:0], out_tr[s]};
            f2 = {f2[46:0], out_tr[s + 49]};
            if (!oe_tr[s] || !oe_tr[s + 49]) bad++;
        end
        for (int s = 0; s < 100; s++) if (dn_tr[s]) dones++;
        chk("gap0_frame1", f1, 48'h40_0000_0000_95);
        chk("gap0_frame2", f2, 48'h40_0000_0000_95);
        chk("gap0_oe_runs", 48'(bad), 48'd0);
        chk("gap0_idle_pre", oe_tr[0], 1'b0);
        chk("gap0_idle_between", {oe_tr[48], oe_tr[49], oe_tr[50]}, 3'b101);
        chk("gap0_done_pos", {dn_tr[47], dn_tr[48], dn_tr[49], dn_tr[97]}, 4'b0101);
        chk("gap0_done_count", 48'(dones), 48'd2);

        busy_bad = 0;
        for (int s = 0; s < 80; s++) begin
            tick();
            if (s == 79 && busy0) busy_bad++;
        end
        chk("gap0_drain_busy", 48'(busy_bad), 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
